lsu_mmio_bridge: RTL and testbench
==================================

Name: lsu_mmio_bridge

Overview:
- Sits between the LSU and the memory-side ports; decodes each load/store address and forwards it either to the CLINT register port or to the main memory request channel.
- Registers every request once, drives the CLINT select/write/size strobes for exactly one cycle, and returns a single-cycle response pulse to the LSU.
- Serialises traffic: one outstanding access at a time.

Parameters:
- DATA_WIDTH, 64, data bus width for LSU, CLINT and memory.
- ADDR_WIDTH, 64, LSU/memory address width.
- CLINT_ADDR_WIDTH, 16, width of the CLINT offset port.
- CLINT_BASE, 64'h0200_0000, base of the CLINT window; window size is 2**CLINT_ADDR_WIDTH.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- lsu_req_valid  in  1  LSU request valid
- lsu_req_ready  out  1  bridge can accept a request
- lsu_addr  in  ADDR_WIDTH  byte address
- lsu_wdata  in  DATA_WIDTH  store data, LSB-aligned
- lsu_wen  in  1  1 = store, 0 = load
- lsu_size  in  3  {unsigned, log2 bytes}, same encoding as the CLINT port
- lsu_resp_valid  out  1  one-cycle response pulse
- lsu_rdata  out  DATA_WIDTH  load data, valid with lsu_resp_valid
- lsu_resp_err  out  1  access error, valid with lsu_resp_valid
- clint_addr  out  CLINT_ADDR_WIDTH  offset into the CLINT window
- clint_wdata  out  DATA_WIDTH  CLINT write data
- clint_wen  out  1  CLINT write enable
- clint_sel  out  1  CLINT select
- clint_size  out  3  CLINT access size
- clint_rdata  in  DATA_WIDTH  CLINT read data, registered inside the CLINT
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts the request
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_wen  out  1  memory write
- mem_size  out  3  memory access size
- mem_resp_valid  in  1  memory response pulse
- mem_rdata  in  DATA_WIDTH  memory read data

Behaviour:
- Reset (reset low, asynchronous) returns the block to IDLE and clears all request registers.
- Reset values of outputs:
  - lsu_req_ready = 1 (IDLE).
  - All other outputs = 0, including clint_sel, clint_wen, mem_req_valid, lsu_resp_valid, lsu_rdata and lsu_resp_err.
- FSM states: IDLE, CLINT_ACC, CLINT_RSP, MEM_REQ, MEM_WAIT.
- lsu_req_ready = (state == IDLE).
- Handshake on lsu_req_valid & lsu_req_ready at edge T:
  - addr/wdata/wen/size are latched.
  - hit = (lsu_addr >= CLINT_BASE) && (lsu_addr < CLINT_BASE + 2**CLINT_ADDR_WIDTH).
  - hit: go to CLINT_ACC; otherwise go to MEM_REQ.
- CLINT_ACC (cycle T+1):
  - clint_sel = 1 for exactly this cycle.
  - clint_wen = latched wen; clint_addr = latched addr[CLINT_ADDR_WIDTH-1:0]; clint_size and clint_wdata from the latched request.
  - Next state: CLINT_RSP.
- CLINT_RSP (cycle T+2):
  - lsu_resp_valid = 1.
  - lsu_rdata = clint_rdata for loads, 0 for stores; err = 0.
  - Next state: IDLE.
  - CLINT latency is therefore fixed at 2 cycles from acceptance.
- MEM_REQ:
  - mem_req_valid = 1 with latched fields, held stable until mem_req_ready.
  - On the handshake, go to MEM_WAIT.
  - If mem_req_ready is already 1 in the first MEM_REQ cycle, that single cycle completes the handshake.
- MEM_WAIT:
  - On mem_resp_valid: lsu_resp_valid = 1 in the same cycle, lsu_rdata = mem_rdata, then go to IDLE.
  - The response is combinational from mem_resp_valid; no extra buffering.
  - mem_resp_valid outside MEM_WAIT is ignored.
- When lsu_resp_valid = 0, lsu_rdata = 0.
- No back-to-back overlap: a new request is accepted at the earliest in the cycle after the response pulse, when state is IDLE again.
- lsu_req_valid dropping while not ready has no effect; nothing is latched.
- Reset asserted mid-access aborts it immediately; no response is ever issued for the aborted access.
- Address boundaries:
  - CLINT_BASE + 2**CLINT_ADDR_WIDTH - 1 is a hit.
  - CLINT_BASE - 1 and CLINT_BASE + 2**CLINT_ADDR_WIDTH go to memory.
  - Comparisons use full ADDR_WIDTH with no wrap.

Optional Feature:
- Macro: LSU_MMIO_MISALIGN_CHK_EN.
- Defined:
  - At acceptance, if the latched address is not aligned to 2**size[1:0] bytes, enter CLINT_RSP directly with lsu_resp_err = 1 and lsu_rdata = 0.
  - Neither clint_sel nor mem_req_valid is asserted.
  - Error latency is 1 cycle after acceptance.
- Undefined: no alignment check; lsu_resp_err is tied to 0.

Decomposition:
- Shared package holds:
  - FSM state enum.
  - Size encoding constants (SZ_B=0, SZ_H=1, SZ_W=2, SZ_D=3, unsigned bit = 2).
  - CLINT_BASE default.
- One natural sub-module, lsu_mmio_decode: combinational address-range hit (plus the alignment check when the macro is defined), reused later by other MMIO windows.

Test Plan:
- CLINT read:
  - Stimulus: load at 0x0200_BFF8, size 3.
  - Response: clint_sel = 1 one cycle after acceptance with clint_addr = 16'hBFF8, clint_wen = 0; lsu_resp_valid the next cycle with lsu_rdata equal to clint_rdata; err = 0.
- CLINT write:
  - Stimulus: store 64'h1234 to 0x0200_4000.
  - Response: one cycle with clint_sel = 1, clint_wen = 1, clint_wdata = 64'h1234; response pulse one cycle later with lsu_rdata = 0.
- Memory path:
  - Stimulus: load at 0x8000_0000 with mem_req_ready held low for 3 cycles, then mem_resp_valid 2 cycles after the handshake.
  - Response: mem_req_valid held for 4 cycles with stable fields; lsu_resp_valid coincides with mem_resp_valid; lsu_req_ready = 0 throughout.
- Boundaries:
  - Stimulus: addresses 0x01FF_FFFF, 0x0200_0000, 0x0200_FFFF, 0x0201_0000.
  - Response: memory, CLINT, CLINT, memory respectively.
- Reset:
  - Stimulus: reset asserted while in MEM_WAIT, then mem_resp_valid arrives after release.
  - Response: all outputs return to reset values asynchronously; no lsu_resp_valid pulse; lsu_req_ready = 1.
- Misalignment (with LSU_MMIO_MISALIGN_CHK_EN):
  - Stimulus: load size 2 at 0x0200_4002.
  - Response: lsu_resp_err = 1 one cycle after acceptance; clint_sel never asserted.

Source files
------------

// File: rtl/lsu_mmio_bridge_pkg.sv
// Shared types and constants for the LSU MMIO bridge.
// Build option: LSU_MMIO_MISALIGN_CHK_EN enables the alignment check.
package lsu_mmio_bridge_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLINT_ACC,
        S_CLINT_RSP,
        S_MEM_REQ,
        S_MEM_WAIT
    } state_e;

    localparam logic [2:0] SZ_B = 3'd0;
    localparam logic [2:0] SZ_H = 3'd1;
    localparam logic [2:0] SZ_W = 3'd2;
    localparam logic [2:0] SZ_D = 3'd3;
    localparam int SZ_UNSIGNED_BIT = 2;

    localparam logic [63:0] CLINT_BASE_DEF = 64'h0000_0000_0200_0000;

endpackage

// File: rtl/lsu_mmio_decode.sv
// Combinational MMIO window decode: range hit and optional alignment check.
// Build option: LSU_MMIO_MISALIGN_CHK_EN adds the size port and misalign flag.
module lsu_mmio_decode
    import lsu_mmio_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int WIN_WIDTH  = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE = '0
) (
    input  logic [ADDR_WIDTH-1:0] addr,
`ifdef LSU_MMIO_MISALIGN_CHK_EN
    input  logic [1:0]            size,
    output logic                  misalign,
`endif
    output logic                  hit
);

    // One extra bit keeps the window limit from wrapping at the top.
    localparam logic [ADDR_WIDTH:0] WIN =
        (ADDR_WIDTH+1)'(1) << WIN_WIDTH;
    localparam logic [ADDR_WIDTH:0] LIMIT = {1'b0, BASE} + WIN;

    logic [ADDR_WIDTH:0] addr_x;

    assign addr_x = {1'b0, addr};
    assign hit = (addr_x >= {1'b0, BASE}) && (addr_x < LIMIT);

`ifdef LSU_MMIO_MISALIGN_CHK_EN
    always_comb begin
        misalign = 1'b0;
        unique case (size)
            SZ_B[1:0]: misalign = 1'b0;
            SZ_H[1:0]: misalign = addr[0];
            SZ_W[1:0]: misalign = |addr[1:0];
            default:   misalign = |addr[2:0];
        endcase
    end
`endif

endmodule

// File: rtl/lsu_mmio_bridge.sv
// Routes LSU accesses to the CLINT port or main memory, one at a time.
// Build option: LSU_MMIO_MISALIGN_CHK_EN returns an error on misaligned access.
module lsu_mmio_bridge
    import lsu_mmio_bridge_pkg::*;
#(
    parameter int DATA_WIDTH       = 64,
    parameter int ADDR_WIDTH       = 64,
    parameter int CLINT_ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] CLINT_BASE =
        ADDR_WIDTH'(CLINT_BASE_DEF)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        lsu_req_valid,
    output logic                        lsu_req_ready,
    input  logic [ADDR_WIDTH-1:0]       lsu_addr,
    input  logic [DATA_WIDTH-1:0]       lsu_wdata,
    input  logic                        lsu_wen,
    input  logic [2:0]                  lsu_size,
    output logic                        lsu_resp_valid,
    output logic [DATA_WIDTH-1:0]       lsu_rdata,
    output logic                        lsu_resp_err,
    output logic [CLINT_ADDR_WIDTH-1:0] clint_addr,
    output logic [DATA_WIDTH-1:0]       clint_wdata,
    output logic                        clint_wen,
    output logic                        clint_sel,
    output logic [2:0]                  clint_size,
    input  logic [DATA_WIDTH-1:0]       clint_rdata,
    output logic                        mem_req_valid,
    input  logic                        mem_req_ready,
    output logic [ADDR_WIDTH-1:0]       mem_addr,
    output logic [DATA_WIDTH-1:0]       mem_wdata,
    output logic                        mem_wen,
    output logic [2:0]                  mem_size,
    input  logic                        mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]       mem_rdata
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  wen_q, wen_d;
    logic [2:0]            size_q, size_d;
    logic                  hit;
    logic                  rsp_zero;
`ifdef LSU_MMIO_MISALIGN_CHK_EN
    logic                  misalign;
    logic                  err_q, err_d;
`endif

    lsu_mmio_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .WIN_WIDTH  (CLINT_ADDR_WIDTH),
        .BASE       (CLINT_BASE)
    ) u_decode (
        .addr     (lsu_addr),
`ifdef LSU_MMIO_MISALIGN_CHK_EN
        .size     (lsu_size[1:0]),
        .misalign (misalign),
`endif
        .hit      (hit)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wen_q   <= 1'b0;
            size_q  <= '0;
`ifdef LSU_MMIO_MISALIGN_CHK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wen_q   <= wen_d;
            size_q  <= size_d;
`ifdef LSU_MMIO_MISALIGN_CHK_EN
            err_q   <= err_d;
`endif
        end
    end

`ifdef LSU_MMIO_MISALIGN_CHK_EN
    assign rsp_zero = wen_q | err_q;
`else
    assign rsp_zero = wen_q;
`endif

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        wen_d          = wen_q;
        size_d         = size_q;
`ifdef LSU_MMIO_MISALIGN_CHK_EN
        err_d          = err_q;
`endif
        lsu_req_ready  = 1'b0;
        lsu_resp_valid = 1'b0;
        lsu_rdata      = '0;
        lsu_resp_err   = 1'b0;
        clint_addr     = '0;
        clint_wdata    = '0;
        clint_wen      = 1'b0;
        clint_sel      = 1'b0;
        clint_size     = '0;
        mem_req_valid  = 1'b0;
        mem_addr       = '0;
        mem_wdata      = '0;
        mem_wen        = 1'b0;
        mem_size       = '0;

        unique case (state_q)
            S_IDLE: begin
                lsu_req_ready = 1'b1;
                if (lsu_req_valid) begin
                    addr_d  = lsu_addr;
                    wdata_d = lsu_wdata;
                    wen_d   = lsu_wen;
                    size_d  = lsu_size;
`ifdef LSU_MMIO_MISALIGN_CHK_EN
                    err_d   = misalign;
                    if (misalign) begin
                        state_d = S_CLINT_RSP;
                    end else
`endif
                    if (hit) begin
                        state_d = S_CLINT_ACC;
                    end else begin
                        state_d = S_MEM_REQ;
                    end
                end
            end
            S_CLINT_ACC: begin
                clint_sel   = 1'b1;
                clint_wen   = wen_q;
                clint_addr  = addr_q[CLINT_ADDR_WIDTH-1:0];
                clint_wdata = wdata_q;
                clint_size  = size_q;
                state_d     = S_CLINT_RSP;
            end
            S_CLINT_RSP: begin
                lsu_resp_valid = 1'b1;
                lsu_rdata      = rsp_zero ? '0 : clint_rdata;
`ifdef LSU_MMIO_MISALIGN_CHK_EN
                lsu_resp_err   = err_q;
`endif
                state_d        = S_IDLE;
            end
            S_MEM_REQ: begin
                mem_req_valid = 1'b1;
                mem_addr      = addr_q;
                mem_wdata     = wdata_q;
                mem_wen       = wen_q;
                mem_size      = size_q;
                if (mem_req_ready) begin
                    state_d = S_MEM_WAIT;
                end
            end
            S_MEM_WAIT: begin
                // Response passes straight through from the memory side.
                if (mem_resp_valid) begin
                    lsu_resp_valid = 1'b1;
                    lsu_rdata      = mem_rdata;
                    state_d        = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_lsu_mmio_bridge.sv
// Directed and randomized bench for lsu_mmio_bridge with a reference model.
// Honors LSU_MMIO_MISALIGN_CHK_EN the same way the design does.
module tb_lsu_mmio_bridge;

    localparam logic [63:0] BASE = 64'h0200_0000;
    localparam logic [63:0] WSIZE = 64'h1_0000;

    logic        clock;
    logic        reset;
    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic [63:0] lsu_addr;
    logic [63:0] lsu_wdata;
    logic        lsu_wen;
    logic [2:0]  lsu_size;
    logic        lsu_resp_valid;
    logic [63:0] lsu_rdata;
    logic        lsu_resp_err;
    logic [15:0] clint_addr;
    logic [63:0] clint_wdata;
    logic        clint_wen;
    logic        clint_sel;
    logic [2:0]  clint_size;
    logic [63:0] clint_rdata;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_wen;
    logic [2:0]  mem_size;
    logic        mem_resp_valid;
    logic [63:0] mem_rdata;

    int checks;
    int failures;

    lsu_mmio_bridge dut (
        .clock          (clock),
        .reset          (reset),
        .lsu_req_valid  (lsu_req_valid),
        .lsu_req_ready  (lsu_req_ready),
        .lsu_addr       (lsu_addr),
        .lsu_wdata      (lsu_wdata),
        .lsu_wen        (lsu_wen),
        .lsu_size       (lsu_size),
        .lsu_resp_valid (lsu_resp_valid),
        .lsu_rdata      (lsu_rdata),
        .lsu_resp_err   (lsu_resp_err),
        .clint_addr     (clint_addr),
        .clint_wdata    (clint_wdata),
        .clint_wen      (clint_wen),
        .clint_sel      (clint_sel),
        .clint_size     (clint_size),
        .clint_rdata    (clint_rdata),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_wen        (mem_wen),
        .mem_size       (mem_size),
        .mem_resp_valid (mem_resp_valid),
        .mem_rdata      (mem_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete access; expectations come from address arithmetic only.
    task automatic access(input logic [63:0] a, input logic [63:0] wd,
                          input logic we, input logic [2:0] sz,
                          input int rdy_dly, input int rsp_dly);
        logic        hit;
        bit          mis;
        logic [63:0] rv;
        hit = (a >= BASE) && (a < BASE + WSIZE);
        mis = 0;
`ifdef LSU_MMIO_MISALIGN_CHK_EN
        mis = (a % (64'd1 << sz[1:0])) != 0;
`endif
        rv = {$urandom, $urandom};
        @(negedge clock);
        lsu_req_valid = 1'b1;
        lsu_addr      = a;
        lsu_wdata     = wd;
        lsu_wen       = we;
        lsu_size      = sz;
        #1 chk("ready_idle", 64'(lsu_req_ready), 64'd1);
        @(posedge clock);
        @(negedge clock);
        lsu_req_valid = 1'b0;
        lsu_addr      = {$urandom, $urandom};
        lsu_wdata     = {$urandom, $urandom};
        lsu_wen       = 1'($urandom);
        clint_rdata   = rv;
        if (mis) begin
            #1;
            chk("mis_resp", 64'(lsu_resp_valid), 64'd1);
            chk("mis_err", 64'(lsu_resp_err), 64'd1);
            chk("mis_rdata", lsu_rdata, 64'd0);
            chk("mis_sel", 64'(clint_sel), 64'd0);
            chk("mis_memv", 64'(mem_req_valid), 64'd0);
            @(negedge clock);
        end else if (hit) begin
            #1;
            chk("cl_sel", 64'(clint_sel), 64'd1);
            chk("cl_wen", 64'(clint_wen), 64'(we));
            chk("cl_addr", 64'(clint_addr), a % WSIZE);
            chk("cl_size", 64'(clint_size), 64'(sz));
            chk("cl_wdata", clint_wdata, wd);
            chk("cl_noresp", 64'(lsu_resp_valid), 64'd0);
            chk("cl_rd0", lsu_rdata, 64'd0);
            chk("cl_busy", 64'(lsu_req_ready), 64'd0);
            chk("cl_memv", 64'(mem_req_valid), 64'd0);
            @(negedge clock);
            #1;
            chk("cl_resp", 64'(lsu_resp_valid), 64'd1);
            chk("cl_rdata", lsu_rdata, we ? 64'd0 : rv);
            chk("cl_err", 64'(lsu_resp_err), 64'd0);
            chk("cl_sel_off", 64'(clint_sel), 64'd0);
            @(negedge clock);
        end else begin
            for (int i = 0; i <= rdy_dly; i++) begin
                mem_req_ready  = (i == rdy_dly);
                mem_resp_valid = 1'($urandom);
                #1;
                chk("mem_v", 64'(mem_req_valid), 64'd1);
                chk("mem_addr", mem_addr, a);
                chk("mem_wdata", mem_wdata, wd);
                chk("mem_wen", 64'(mem_wen), 64'(we));
                chk("mem_size", 64'(mem_size), 64'(sz));
                chk("mem_busy", 64'(lsu_req_ready), 64'd0);
                chk("mem_noresp", 64'(lsu_resp_valid), 64'd0);
                chk("mem_nosel", 64'(clint_sel), 64'd0);
                @(negedge clock);
            end
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b0;
            for (int i = 0; i < rsp_dly; i++) begin
                #1;
                chk("wait_v", 64'(mem_req_valid), 64'd0);
                chk("wait_noresp", 64'(lsu_resp_valid), 64'd0);
                chk("wait_rd0", lsu_rdata, 64'd0);
                chk("wait_busy", 64'(lsu_req_ready), 64'd0);
                @(negedge clock);
            end
            mem_rdata      = rv;
            mem_resp_valid = 1'b1;
            #1;
            chk("mem_resp", 64'(lsu_resp_valid), 64'd1);
            chk("mem_rdata", lsu_rdata, rv);
            chk("mem_err", 64'(lsu_resp_err), 64'd0);
            @(negedge clock);
            mem_resp_valid = 1'b0;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ready"}, 64'(lsu_req_ready), 64'd1);
        chk({tag, "_resp"}, 64'(lsu_resp_valid), 64'd0);
        chk({tag, "_rdata"}, lsu_rdata, 64'd0);
        chk({tag, "_err"}, 64'(lsu_resp_err), 64'd0);
        chk({tag, "_sel"}, 64'(clint_sel), 64'd0);
        chk({tag, "_cwen"}, 64'(clint_wen), 64'd0);
        chk({tag, "_caddr"}, 64'(clint_addr), 64'd0);
        chk({tag, "_memv"}, 64'(mem_req_valid), 64'd0);
        chk({tag, "_maddr"}, mem_addr, 64'd0);
    endtask

    initial begin
        logic [63:0] bnd [4];
        logic [63:0] a;
        int          k;
        checks         = 0;
        failures       = 0;
        reset          = 1'b0;
        lsu_req_valid  = 1'b0;
        lsu_addr       = '0;
        lsu_wdata      = '0;
        lsu_wen        = 1'b0;
        lsu_size       = '0;
        clint_rdata    = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_rdata      = '0;
        bnd[0] = 64'h01FF_FFFF;
        bnd[1] = 64'h0200_0000;
        bnd[2] = 64'h0200_FFFF;
        bnd[3] = 64'h0201_0000;

        @(negedge clock);
        @(negedge clock);
        #1 check_reset_vals("rst");
        @(negedge clock);
        reset = 1'b1;

        access(64'h0200_BFF8, 64'h0, 1'b0, 3'd3, 0, 0);
        access(64'h0200_4000, 64'h1234, 1'b1, 3'd3, 0, 0);
        access(64'h8000_0000, 64'h0, 1'b0, 3'd3, 3, 2);
        foreach (bnd[i]) access(bnd[i], 64'h55, 1'b0, 3'd0, 1, 1);
`ifdef LSU_MMIO_MISALIGN_CHK_EN
        access(64'h0200_4002, 64'h0, 1'b0, 3'd2, 0, 0);
`endif

        // Abort an access in MEM_WAIT with an asynchronous reset.
        @(negedge clock);
        lsu_req_valid = 1'b1;
        lsu_addr      = 64'h8000_1000;
        lsu_wen       = 1'b0;
        lsu_size      = 3'd3;
        @(posedge clock);
        @(negedge clock);
        lsu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        #1 chk("ab_memv", 64'(mem_req_valid), 64'd1);
        @(negedge clock);
        mem_req_ready = 1'b0;
        #1 chk("ab_wait", 64'(mem_req_valid), 64'd0);
        chk("ab_busy", 64'(lsu_req_ready), 64'd0);
        #1 reset = 1'b0;
        #1 check_reset_vals("ab_rst");
        @(negedge clock);
        reset          = 1'b1;
        mem_rdata      = 64'hDEAD_BEEF;
        mem_resp_valid = 1'b1;
        #1 chk("ab_noresp", 64'(lsu_resp_valid), 64'd0);
        chk("ab_rd0", lsu_rdata, 64'd0);
        chk("ab_ready", 64'(lsu_req_ready), 64'd1);
        @(negedge clock);
        mem_resp_valid = 1'b0;

        for (int n = 0; n < 60; n++) begin
            k = $urandom_range(0, 3);
            case (k)
                0: a = BASE + 64'($urandom_range(0, 65535));
                1: a = {32'h0, $urandom} | 64'h8000_0000;
                2: a = bnd[$urandom_range(0, 3)];
                default: a = {$urandom, $urandom};
            endcase
            access(a, {$urandom, $urandom}, 1'($urandom),
                   3'($urandom_range(0, 7)),
                   $urandom_range(0, 3), $urandom_range(0, 3));
            for (int j = $urandom_range(0, 2); j > 0; j--) begin
                mem_resp_valid = 1'($urandom);
                #1 chk("idle_noresp", 64'(lsu_resp_valid), 64'd0);
                chk("idle_ready", 64'(lsu_req_ready), 64'd1);
                @(negedge clock);
                mem_resp_valid = 1'b0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
